// File: rtl/ov_fifo_capture.sv
// OV7670 / AL422 frame capture: stores one frame between two camera VSYNCs, then
// drains it with a self-generated read clock and packs byte pairs into RGB565 pixels.
`timescale 1ns/1ps
module ov_fifo_capture #(
    parameter int H_PIX   = 640,
    parameter int V_PIX   = 480,
    parameter int RST_CYC = 4,
    parameter int CNT_W   = 19
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        OV_vsync,
    input  logic [7:0]  OV_data,
    output logic        OV_wrst,
    output logic        OV_wen,
    output logic        OV_rrst,
    output logic        OV_oe,
    output logic        OV_rclk,
    input  logic        wr_afull,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        frame_done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_VS1 = 3'd1;
    localparam logic [2:0] WR_RST   = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] RD_RST   = 3'd4;
    localparam logic [2:0] READ     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam int               RST_W    = $clog2(2 * RST_CYC) + 1;
    localparam logic [RST_W-1:0] WR_LAST  = RST_W'(RST_CYC - 1);
    localparam logic [RST_W-1:0] RD_LAST  = RST_W'(2 * RST_CYC - 1);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(H_PIX * V_PIX - 1);

    logic [2:0]       state;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] pix_cnt;
    logic             vs_p0, vs_p1, vs_p2;
    logic             vs_rise;
    logic             rclk;
    logic             byte_phase;
    logic [7:0]       hi_byte;
    logic             stall;
    logic             take_byte;
    logic             last_pix;

    // VSYNC synchronizer and rising-edge detect
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_p0 <= 1'b0;
            vs_p1 <= 1'b0;
            vs_p2 <= 1'b0;
        end else begin
            vs_p0 <= OV_vsync;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
        end
    end

    assign vs_rise = vs_p1 & ~vs_p2;

    // A byte is taken on the 1->0 read-clock step, a full cycle after the rising edge.
    assign stall     = wr_afull & ~rclk;
    assign take_byte = (state == READ) & rclk;
    assign last_pix  = pix_valid & (pix_cnt == PIX_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            pix_cnt     <= '0;
            rclk        <= 1'b0;
            byte_phase  <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_done)
                        state <= WAIT_VS1;
                end
                WAIT_VS1: begin
                    if (!init_done) begin
                        state <= IDLE;
                    end else if (vs_rise) begin
                        state   <= WR_RST;
                        rst_cnt <= '0;
                    end
                end
                WR_RST: begin
                    if (rst_cnt == WR_LAST) begin
                        rst_cnt <= '0;
                        state   <= WRITE;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                WRITE: begin
                    if (vs_rise) begin
                        state   <= RD_RST;
                        rst_cnt <= '0;
                        rclk    <= 1'b0;
                    end
                end
                RD_RST: begin
                    // An even number of toggles leaves rclk low on entry to READ.
                    rclk <= ~rclk;
                    if (rst_cnt == RD_LAST) begin
                        rst_cnt     <= '0;
                        state       <= READ;
                        frame_start <= 1'b1;
                        byte_phase  <= 1'b0;
                        pix_cnt     <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                READ: begin
                    if (pix_valid)
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    if (last_pix) begin
                        state <= DONE;
                        rclk  <= 1'b0;
                    end else if (!stall) begin
                        rclk <= ~rclk;
                    end
                    if (take_byte) begin
                        byte_phase <= ~byte_phase;
                        if (byte_phase) begin
                            pix_data  <= {hi_byte, OV_data};
                            pix_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    rclk       <= 1'b0;
                    pix_cnt    <= '0;
                    byte_phase <= 1'b0;
                    state      <= WAIT_VS1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // First byte of a pair is held until its partner arrives.
    always_ff @(posedge sys_clk) begin
        if (take_byte && !byte_phase)
            hi_byte <= OV_data;
    end

    assign OV_wrst    = (state != WR_RST);
    assign OV_wen     = (state == WR_RST) || (state == WRITE);
    assign OV_rrst    = (state != RD_RST);
    assign OV_oe      = !((state == RD_RST) || (state == READ));
    assign OV_rclk    = rclk;
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_ov_fifo_capture.sv
// Scoreboard bench for ov_fifo_capture with a small AL422 read-side model (4x2 frame).
`timescale 1ns/1ps
module tb_ov_fifo_capture;
    logic        sys_clk   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        init_done = 1'b0;
    logic        OV_vsync  = 1'b0;
    logic [7:0]  OV_data   = 8'h00;
    logic        wr_afull  = 1'b0;
    logic        OV_wrst, OV_wen, OV_rrst, OV_oe, OV_rclk;
    logic [15:0] pix_data;
    logic        pix_valid, frame_start, frame_done;

    int checks    = 0;
    int errors    = 0;
    int pix_seen  = 0;
    int fs_seen   = 0;
    int fd_seen   = 0;
    int rd_ptr    = 0;
    int data_mode = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ramp_pix [8] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607,
                                  16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};

    ov_fifo_capture #(.H_PIX(4), .V_PIX(2), .RST_CYC(4), .CNT_W(19)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .init_done(init_done), .OV_vsync(OV_vsync),
        .OV_data(OV_data), .OV_wrst(OV_wrst), .OV_wen(OV_wen), .OV_rrst(OV_rrst),
        .OV_oe(OV_oe), .OV_rclk(OV_rclk), .wr_afull(wr_afull), .pix_data(pix_data),
        .pix_valid(pix_valid), .frame_start(frame_start), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    // AL422 read side: pointer cleared by rclk edges under rrst, data follows each rising edge
    initial begin
        forever begin
            @(posedge OV_rclk);
            #1;
            if (!OV_rrst) begin
                rd_ptr = 0;
            end else begin
                OV_data = (data_mode == 0) ? 8'hAF : 8'(rd_ptr);
                rd_ptr++;
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_vsync();
        OV_vsync = 1'b1;
        tick(3);
        OV_vsync = 1'b0;
    endtask

    task automatic capture();
        pulse_vsync();
        tick(197);
        pulse_vsync();
    endtask

    task automatic push_const();
        repeat (8) exp_q.push_back(16'hAFAF);
    endtask

    task automatic push_ramp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ramp_pix[i]);
    endtask

    task automatic wait_pix(input int base, input int n, input string name);
        int t = 0;
        while ((pix_seen - base) < n && t < 1000) begin
            tick(1);
            t++;
        end
        check(name, 32'((pix_seen - base) >= n), 1);
    endtask

    task automatic wait_done(input int base, input string name);
        int t = 0;
        while (fd_seen == base && t < 1000) begin
            tick(1);
            t++;
        end
        check(name, fd_seen - base, 1);
    endtask

    task automatic wait_wen(input string name);
        int t = 0;
        while (!OV_wen && t < 20) begin
            tick(1);
            t++;
        end
        check(name, OV_wen, 1);
    endtask

    initial begin
        int b_pix, b_fs, b_fd, low, bad, bad_r, bad_v;
        logic [15:0] exp_pix;

        // monitor: pops the scoreboard on every pix_valid, counts frame pulses
        fork
            forever begin
                @(negedge sys_clk);
                if (pix_valid) begin
                    pix_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pix_unexpected: got %h expected no pixel", pix_data);
                    end else begin
                        exp_pix = exp_q.pop_front();
                        check("pix_data", pix_data, exp_pix);
                    end
                    check("pv_fd_exclusive", frame_done, 0);
                end
                if (frame_start) fs_seen++;
                if (frame_done)  fd_seen++;
            end
        join_none

        tick(3);
        check("reset_ctl", {OV_wrst, OV_wen, OV_rrst, OV_oe, OV_rclk, pix_valid, frame_start, frame_done}, 8'b1011_0000);
        check("reset_pix", pix_data, 16'h0000);
        rst_n = 1'b1;

        // test 1: constant data, timing of write-side controls
        data_mode = 0;
        init_done = 1'b1;
        tick(4);
        push_const();
        b_pix = pix_seen; b_fs = fs_seen; b_fd = fd_seen;
        OV_vsync = 1'b1;
        for (int i = 0; i < 20 && OV_wrst; i++) begin
            tick(1);
            if (i == 2) OV_vsync = 1'b0;
        end
        OV_vsync = 1'b0;
        low = 0;
        while (!OV_wrst && low < 20) begin
            tick(1);
            low++;
        end
        check("t1_wrst_low_cycles", low, 4);
        bad = 0;
        for (int i = 0; i < 190; i++) begin
            if (!OV_wen) bad++;
            tick(1);
        end
        check("t1_wen_held", bad, 0);
        pulse_vsync();
        wait_done(b_fd, "t1_frame_done");
        tick(2);
        check("t1_pix_count", pix_seen - b_pix, 8);
        check("t1_frame_start", fs_seen - b_fs, 1);
        check("t1_oe_after", OV_oe, 1);
        check("t1_wen_after", OV_wen, 0);

        // test 2: ramp data, byte order and read-clock count
        data_mode = 1;
        push_ramp(8);
        b_pix = pix_seen; b_fd = fd_seen;
        capture();
        wait_done(b_fd, "t2_frame_done");
        tick(2);
        check("t2_pix_count", pix_seen - b_pix, 8);
        check("t2_rclk_rises", rd_ptr, 16);

        // test 3: back-pressure after the third pixel
        push_ramp(8);
        b_pix = pix_seen; b_fd = fd_seen;
        capture();
        wait_pix(b_pix, 3, "t3_reach_3");
        wr_afull = 1'b1;
        bad_r = 0; bad_v = 0;
        repeat (10) begin
            tick(1);
            if (OV_rclk)   bad_r++;
            if (pix_valid) bad_v++;
        end
        wr_afull = 1'b0;
        check("t3_rclk_stalled", bad_r, 0);
        check("t3_no_pix_stall", bad_v, 0);
        check("t3_pix_during", pix_seen - b_pix, 3);
        wait_done(b_fd, "t3_frame_done");
        tick(2);
        check("t3_pix_count", pix_seen - b_pix, 8);
        check("t3_rclk_rises", rd_ptr, 16);

        // test 4: reset in the middle of READ
        push_ramp(5);
        b_pix = pix_seen; b_fd = fd_seen;
        capture();
        wait_pix(b_pix, 5, "t4_reach_5");
        rst_n = 1'b0;
        #1;
        check("t4_reset_ctl", {OV_wrst, OV_wen, OV_rrst, OV_oe, OV_rclk, pix_valid, frame_start, frame_done}, 8'b1011_0000);
        check("t4_reset_pix", pix_data, 16'h0000);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("t4_no_frame_done", fd_seen - b_fd, 0);
        check("t4_pix_count", pix_seen - b_pix, 5);
        b_pix = pix_seen;
        pulse_vsync();
        tick(100);
        check("t4_armed_by_first", OV_wen, 1);
        check("t4_no_read_yet", pix_seen - b_pix, 0);
        push_ramp(8);
        pulse_vsync();
        wait_done(b_fd, "t4_frame_done");
        tick(2);
        check("t4_refill_count", pix_seen - b_pix, 8);

        // test 5: vsync ignored while init_done is low
        data_mode = 0;
        init_done = 1'b0;
        tick(2);
        b_pix = pix_seen; b_fd = fd_seen;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) OV_vsync = 1'b1;
            if (i % 200 == 3) OV_vsync = 1'b0;
            if (OV_wen || !OV_oe) bad++;
            tick(1);
        end
        OV_vsync = 1'b0;
        check("t5_idle_outputs", bad, 0);
        check("t5_no_pix", pix_seen - b_pix, 0);
        init_done = 1'b1;
        tick(3);
        push_const();
        pulse_vsync();
        wait_wen("t5_first_vsync_arms");
        tick(190);
        pulse_vsync();
        wait_done(b_fd, "t5_frame_done");
        tick(2);
        check("t5_pix_count", pix_seen - b_pix, 8);

        // test 6: extra vsync during READ is ignored
        data_mode = 1;
        push_ramp(8);
        b_pix = pix_seen; b_fd = fd_seen;
        capture();
        wait_pix(b_pix, 2, "t6_in_read");
        pulse_vsync();
        wait_done(b_fd, "t6_frame_done");
        tick(2);
        check("t6_pix_count", pix_seen - b_pix, 8);
        check("t6_oe_after", OV_oe, 1);
        tick(50);
        check("t6_third_ignored", OV_wen, 0);
        push_ramp(8);
        b_fd = fd_seen;
        pulse_vsync();
        wait_wen("t6_fourth_arms");
        tick(190);
        pulse_vsync();
        wait_done(b_fd, "t6_next_frame_done");
        tick(2);
        check("t6_total_pix", pix_seen - b_pix, 16);

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
